// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point add/subtract: IDLE -> ALIGN -> ADD -> NORM -> DONE.
// Define FPU_FAST_ALIGN_EN to do the alignment shift in a single ALIGN cycle.
module fp_addsub_seq #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]   op_a,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]   op_b,
  input  logic                           operation_select,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [EXP_WIDTH+MAN_WIDTH:0]   result,
  output logic                           busy
);

  localparam int W  = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam int SW = MAN_WIDTH + 2;
  localparam int CW = $clog2(MAN_WIDTH + 3);
  localparam logic [EXP_WIDTH-1:0] EXP_ONES = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_next;

  logic                 sign_r;
  logic                 eff_sub_r;
  logic [EXP_WIDTH-1:0] exp_r;
  logic [MAN_WIDTH:0]   big_r;
  logic [MAN_WIDTH:0]   small_r;
  logic [CW-1:0]        cnt_r;
  logic [SW-1:0]        sum_r;
  logic [W-1:0]         result_r;

  logic                 sign_a, sign_b;
  logic [EXP_WIDTH-1:0] exp_a, exp_b;
  logic [MAN_WIDTH:0]   man_a, man_b;
  logic                 a_big;
  logic                 cap_sign;
  logic [EXP_WIDTH-1:0] cap_exp;
  logic [EXP_WIDTH-1:0] cap_diff;
  logic [MAN_WIDTH:0]   cap_big, cap_small;
  logic [CW-1:0]        cap_cnt;
  logic [31:0]          diff32;

  logic                 carry, hidden, sum_zero, low_exp;
  logic [EXP_WIDTH:0]   exp_inc;
  logic [SW-1:0]        sum_calc;

  // Operand unpacking, magnitude ordering and alignment distance at capture.
  always_comb begin
    sign_a = op_a[W-1];
    sign_b = op_b[W-1] ^ operation_select;
    exp_a  = op_a[W-2:MAN_WIDTH];
    exp_b  = op_b[W-2:MAN_WIDTH];
    man_a  = (exp_a == '0) ? '0 : {1'b1, op_a[MAN_WIDTH-1:0]};
    man_b  = (exp_b == '0) ? '0 : {1'b1, op_b[MAN_WIDTH-1:0]};
    a_big  = (op_a[W-2:0] >= op_b[W-2:0]);
    if (a_big) begin
      cap_sign  = sign_a;
      cap_exp   = exp_a;
      cap_diff  = exp_a - exp_b;
      cap_big   = man_a;
      cap_small = man_b;
    end else begin
      cap_sign  = sign_b;
      cap_exp   = exp_b;
      cap_diff  = exp_b - exp_a;
      cap_big   = man_b;
      cap_small = man_a;
    end
    diff32 = 32'(cap_diff);
    if (diff32 > 32'(SW)) begin
      cap_cnt = CW'(SW);
    end else begin
      cap_cnt = CW'(cap_diff);
    end
  end

  // Adder and normalisation status derived from the working registers.
  always_comb begin
    if (eff_sub_r) begin
      sum_calc = {1'b0, big_r} - {1'b0, small_r};
    end else begin
      sum_calc = {1'b0, big_r} + {1'b0, small_r};
    end
    carry    = sum_r[SW-1];
    hidden   = sum_r[SW-2];
    sum_zero = (sum_r == '0);
    low_exp  = (exp_r <= EXP_WIDTH'(1));
    exp_inc  = {1'b0, exp_r} + {{EXP_WIDTH{1'b0}}, 1'b1};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = ALIGN;
        end else begin
          state_next = IDLE;
        end
      end
      ALIGN: begin
`ifdef FPU_FAST_ALIGN_EN
        state_next = ADD;
`else
        if (cnt_r == '0) begin
          state_next = ADD;
        end else begin
          state_next = ALIGN;
        end
`endif
      end
      ADD: state_next = NORM;
      NORM: begin
        // Exponent underflow on a pending left shift also terminates here.
        if (carry || sum_zero || hidden || low_exp) begin
          state_next = DONE;
        end else begin
          state_next = NORM;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      DONE:    out_valid = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  assign result = result_r;

  // Datapath registers: capture, alignment, add, normalise and result packing.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_r    <= 1'b0;
      eff_sub_r <= 1'b0;
      exp_r     <= '0;
      big_r     <= '0;
      small_r   <= '0;
      cnt_r     <= '0;
      sum_r     <= '0;
      result_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_r    <= cap_sign;
            eff_sub_r <= sign_a ^ sign_b;
            exp_r     <= cap_exp;
            big_r     <= cap_big;
            small_r   <= cap_small;
            cnt_r     <= cap_cnt;
          end
        end
        ALIGN: begin
`ifdef FPU_FAST_ALIGN_EN
          small_r <= small_r >> cnt_r;
          cnt_r   <= '0;
`else
          if (cnt_r != '0) begin
            small_r <= small_r >> 1;
            cnt_r   <= cnt_r - CW'(1);
          end
`endif
        end
        ADD: sum_r <= sum_calc;
        NORM: begin
          if (carry) begin
            sum_r <= sum_r >> 1;
            exp_r <= exp_inc[EXP_WIDTH-1:0];
            // Overflow into the all-ones exponent saturates to infinity.
            if (exp_inc >= {1'b0, EXP_ONES}) begin
              result_r <= {sign_r, EXP_ONES, {MAN_WIDTH{1'b0}}};
            end else begin
              result_r <= {sign_r, exp_inc[EXP_WIDTH-1:0], sum_r[MAN_WIDTH:1]};
            end
          end else if (sum_zero) begin
            result_r <= '0;
          end else if (hidden) begin
            result_r <= {sign_r, exp_r, sum_r[MAN_WIDTH-1:0]};
          end else if (low_exp) begin
            exp_r    <= '0;
            result_r <= '0;
          end else begin
            sum_r <= sum_r << 1;
            exp_r <= exp_r - EXP_WIDTH'(1);
          end
        end
        DONE:    result_r <= result_r;
        default: result_r <= result_r;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed scoreboard bench for fp_addsub_seq (single precision defaults).
module tb_fp_addsub_seq;

`ifdef FPU_FAST_ALIGN_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a, op_b;
  logic        operation_select;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  fp_addsub_seq #(.EXP_WIDTH(8), .MAN_WIDTH(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .operation_select(operation_select),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Push expectation, run one operation, compare result, latency and return to IDLE.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic op, input logic [31:0] expv, input int cnt, input int shifts);
    int lat;
    logic [31:0] e;
    int el;
    op_a = a; op_b = b; operation_select = op; in_valid = 1'b1; out_ready = 1'b1;
    exp_q.push_back(expv);
    lat_q.push_back(4 + (FAST ? 0 : cnt) + shifts);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    check({tag, " result"}, result, e);
    check({tag, " latency"}, 32'(lat), 32'(el));
    @(posedge clk); #1;
    check({tag, " back_to_idle"}, {29'd0, in_ready, busy, out_valid}, 32'h4);
  endtask

  initial begin
    int lat;
    logic saw;
    logic [31:0] e;
    rst = 1'b1; in_valid = 1'b0; op_a = 32'h0; op_b = 32'h0;
    operation_select = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {28'd0, in_ready, out_valid, busy, 1'b0}, 32'h8);
    check("reset_result", result, 32'h0);
    rst = 1'b0;

    do_op("one_plus_one",   32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 0, 0);
    do_op("one_plus_half",  32'h3F800000, 32'h3F000000, 1'b0, 32'h3FC00000, 1, 0);
    do_op("half_plus_one",  32'h3F000000, 32'h3F800000, 1'b0, 32'h3FC00000, 1, 0);
    do_op("1p5_minus_one",  32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, 0, 1);
    do_op("two_minus_two",  32'h40000000, 32'h40000000, 1'b1, 32'h00000000, 0, 0);
    do_op("tiny_addend",    32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 25, 0);
    do_op("max_plus_max",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 0, 0);
    do_op("neg1_plus_half", 32'hBF800000, 32'h3F000000, 1'b0, 32'hBF000000, 1, 1);
    do_op("half_minus_one", 32'h3F000000, 32'h3F800000, 1'b1, 32'hBF000000, 1, 1);
    do_op("one_minus_neg1", 32'h3F800000, 32'hBF800000, 1'b1, 32'h40000000, 0, 0);
    do_op("two_plus_one",   32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 1, 0);
    do_op("denorm_flushed", 32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 25, 0);
    do_op("underflow_zero", 32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 0, 0);

    // Back-pressure: result held while out_ready is low, no new acceptance.
    op_a = 32'h40000000; op_b = 32'h3F800000; operation_select = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    exp_q.push_back(32'h40400000);
    @(posedge clk); #1;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    e = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      check("stall_result", result, e);
      check("stall_flags", {29'd0, out_valid, in_ready, busy}, 32'h5);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("stall_release", {29'd0, in_ready, out_valid, busy}, 32'h4);

    // Reset during serial alignment, with in_valid high through the reset cycle.
    op_a = 32'h3F800000; op_b = 32'h30800000; operation_select = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1; in_valid = 1'b1; op_b = 32'h3F800000;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check("mid_reset_flags", {29'd0, in_ready, out_valid, busy}, 32'h4);
    check("mid_reset_result", result, 32'h0);
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      saw = saw | out_valid | busy;
    end
    check("no_stale_after_reset", {31'd0, saw}, 32'd0);

    do_op("after_reset", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
